bus_dma: RTL and testbench

- Bus master that initiates byte transfers on the 24-bit console memory bus: copy (read source, then write destination) or fill (write a constant).
- Drives address, bus_enable and write_enable, and stalls on bus_halt, so SD-backed regions and hblank waits are honoured automatically.
- Programmed by the CPU through a small register window in the peripherals space. Arbitrates with the CPU via bus_request/bus_grant.

---
 rtl/bus_dma.sv | 177 +++++++++++++++++
 tb/tb_bus_dma.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_dma.sv
// Byte-copy / fill DMA master for the 24-bit console memory bus.
// CPU programs it through a 16-entry register window; it arbitrates for the bus by request/grant.
module bus_dma #(
  parameter int LEN_WIDTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_write,
  input  logic [3:0]  cfg_address,
  input  logic [7:0]  cfg_data_in,
  output logic [7:0]  cfg_data_out,
  output logic        bus_request,
  input  logic        bus_grant,
  output logic [23:0] address,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        bus_enable,
  output logic        write_enable,
  input  logic        bus_halt,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, REQ, READ, WRITE, FINISH} state_t;

  state_t               state;
  logic [23:0]          src, dst;
  logic [LEN_WIDTH-1:0] len;
  logic [15:0]          len16;
  logic [7:0]           fill;
  logic                 fill_mode, done_flag;
  logic                 ctrl_wr, cfg_open;

  assign len16    = 16'(len);
  assign ctrl_wr  = cfg_write && (cfg_address == 4'd8);
  assign cfg_open = cfg_write && !busy;

  always_comb begin
    cfg_data_out = 8'h00;
    case (cfg_address)
      4'd0:    cfg_data_out = src[7:0];
      4'd1:    cfg_data_out = src[15:8];
      4'd2:    cfg_data_out = src[23:16];
      4'd3:    cfg_data_out = dst[7:0];
      4'd4:    cfg_data_out = dst[15:8];
      4'd5:    cfg_data_out = dst[23:16];
      4'd6:    cfg_data_out = len16[7:0];
      4'd7:    cfg_data_out = len16[15:8];
      4'd8:    cfg_data_out = {6'b0, done_flag, busy};
      4'd9:    cfg_data_out = fill;
      default: cfg_data_out = 8'h00;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      src          <= '0;
      dst          <= '0;
      len          <= '0;
      fill         <= '0;
      fill_mode    <= 1'b0;
      done_flag    <= 1'b0;
      bus_request  <= 1'b0;
      bus_enable   <= 1'b0;
      write_enable <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      address      <= '0;
      data_out     <= '0;
    end else begin
      done <= 1'b0;
      // Counters are only writable from the CPU while the engine is not running.
      if (cfg_open) begin
        case (cfg_address)
          4'd0:    src[7:0]   <= cfg_data_in;
          4'd1:    src[15:8]  <= cfg_data_in;
          4'd2:    src[23:16] <= cfg_data_in;
          4'd3:    dst[7:0]   <= cfg_data_in;
          4'd4:    dst[15:8]  <= cfg_data_in;
          4'd5:    dst[23:16] <= cfg_data_in;
          4'd6:    len <= LEN_WIDTH'({len16[15:8], cfg_data_in});
          4'd7:    len <= LEN_WIDTH'({cfg_data_in, len16[7:0]});
          4'd9:    fill <= cfg_data_in;
          default: ;
        endcase
      end

      if (ctrl_wr && cfg_data_in[7] && busy) begin
        state        <= FINISH;
        bus_request  <= 1'b0;
        bus_enable   <= 1'b0;
        write_enable <= 1'b0;
        busy         <= 1'b0;
        done         <= 1'b1;
        done_flag    <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (ctrl_wr && cfg_data_in[0]) begin
              fill_mode <= cfg_data_in[1];
              if (len != '0) begin
                state       <= REQ;
                bus_request <= 1'b1;
                busy        <= 1'b1;
                done_flag   <= 1'b0;
              end else begin
                state     <= FINISH;
                done      <= 1'b1;
                done_flag <= 1'b1;
              end
            end
          end
          REQ: begin
            if (bus_grant) begin
              bus_enable <= 1'b1;
              if (fill_mode) begin
                state        <= WRITE;
                address      <= dst;
                data_out     <= fill;
                write_enable <= 1'b1;
              end else begin
                state        <= READ;
                address      <= src;
                write_enable <= 1'b0;
              end
            end
          end
          // An access completes only on an edge where it was visible, granted and not halted.
          READ: begin
            if (!bus_grant) begin
              bus_enable <= 1'b0;
            end else if (!bus_enable) begin
              bus_enable <= 1'b1;
            end else if (!bus_halt) begin
              state        <= WRITE;
              data_out     <= data_in;
              address      <= dst;
              write_enable <= 1'b1;
            end
          end
          WRITE: begin
            if (!bus_grant) begin
              bus_enable   <= 1'b0;
              write_enable <= 1'b0;
            end else if (!bus_enable) begin
              bus_enable   <= 1'b1;
              write_enable <= 1'b1;
            end else if (!bus_halt) begin
              dst <= dst + 24'd1;
              len <= len - LEN_WIDTH'(1);
              if (!fill_mode) src <= src + 24'd1;
              if (len == LEN_WIDTH'(1)) begin
                state        <= FINISH;
                bus_request  <= 1'b0;
                bus_enable   <= 1'b0;
                write_enable <= 1'b0;
                busy         <= 1'b0;
                done         <= 1'b1;
                done_flag    <= 1'b1;
              end else if (fill_mode) begin
                address <= dst + 24'd1;
              end else begin
                state        <= READ;
                address      <= src + 24'd1;
                write_enable <= 1'b0;
              end
            end
          end
          FINISH:  state <= IDLE;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_bus_dma.sv
// Directed bench for bus_dma: copy, fill, halt, grant handshake, boundaries, abort and reset.
// The bus memory returns addr[7:0]+addr[15:8]+1 on reads, and 0xEE while halted.
module tb_bus_dma;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_write = 1'b0;
  logic [3:0]  cfg_address = '0;
  logic [7:0]  cfg_data_in = '0;
  logic [7:0]  cfg_data_out;
  logic        bus_request, bus_grant = 1'b1;
  logic [23:0] address;
  logic [7:0]  data_out, data_in;
  logic        bus_enable, write_enable, bus_halt = 1'b0;
  logic        busy, done;

  assign data_in = bus_halt ? 8'hEE : (address[7:0] + address[15:8] + 8'h01);

  bus_dma #(.LEN_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .cfg_write(cfg_write), .cfg_address(cfg_address),
    .cfg_data_in(cfg_data_in), .cfg_data_out(cfg_data_out), .bus_request(bus_request),
    .bus_grant(bus_grant), .address(address), .data_out(data_out), .data_in(data_in),
    .bus_enable(bus_enable), .write_enable(write_enable), .bus_halt(bus_halt),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, be_cnt = 0;
  logic [23:0] la[$];
  logic [7:0]  ld[$];
  logic        lw[$];
  int          lc[$];

  always @(posedge clk) begin
    cyc++;
    if (bus_enable && bus_grant && !bus_halt && !reset) begin
      la.push_back(address);
      lw.push_back(write_enable);
      ld.push_back(write_enable ? data_out : data_in);
      lc.push_back(cyc);
    end
  end

  always @(negedge clk) if (bus_enable) be_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
    cfg_write = 1'b1; cfg_address = a; cfg_data_in = d;
    @(negedge clk);
    cfg_write = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, output logic [7:0] v);
    cfg_address = a;
    #1 v = cfg_data_out;
  endtask

  task automatic set_xfer(input logic [23:0] s, input logic [23:0] d, input logic [15:0] n);
    cfg_wr(4'd0, s[7:0]);  cfg_wr(4'd1, s[15:8]); cfg_wr(4'd2, s[23:16]);
    cfg_wr(4'd3, d[7:0]);  cfg_wr(4'd4, d[15:8]); cfg_wr(4'd5, d[23:16]);
    cfg_wr(4'd6, n[7:0]);  cfg_wr(4'd7, n[15:8]);
  endtask

  task automatic clr_log();
    la.delete(); ld.delete(); lw.delete(); lc.delete();
    be_cnt = 0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (done !== 1'b1) chk("done_timeout", 0, 1);
  endtask

  task automatic wait_log(input int sz, input int budget);
    int n = 0;
    while (la.size() < sz && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (la.size() < sz) chk("log_timeout", la.size(), sz);
  endtask

  task automatic chk_pair(input int i, input logic [23:0] ra, input logic [23:0] wa,
                          input logic [7:0] d);
    if (la.size() > 2*i+1) begin
      chk("rd_addr", la[2*i], ra);
      chk("rd_we", lw[2*i], 0);
      chk("wr_addr", la[2*i+1], wa);
      chk("wr_data", ld[2*i+1], d);
      chk("wr_we", lw[2*i+1], 1);
    end else begin
      chk("log_short", la.size(), 2*i+2);
    end
  endtask

  logic [7:0] v;

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_req", bus_request, 0);
    chk("rst_be", bus_enable, 0);
    chk("rst_addr", address, 0);
    rd(4'd8, v); chk("rst_status", v, 8'h00);
    reset = 1'b0;
    @(negedge clk);

    // copy 4 bytes, grant already held
    set_xfer(24'h008000, 24'h008100, 16'd4);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    chk("cp_req", bus_request, 1);
    chk("cp_be_lat", bus_enable, 0);
    @(negedge clk);
    chk("cp_be_first", bus_enable, 1);
    chk("cp_addr_first", address, 24'h008000);
    rd(4'd8, v); chk("cp_status_busy", v, 8'h01);
    wait_done(40);
    for (int i = 0; i < 4; i++) chk_pair(i, 24'h008000 + i, 24'h008100 + i, 8'h81 + i);
    chk("cp_be_cycles", be_cnt, 8);
    chk("cp_busy_done", busy, 0);
    @(negedge clk);
    chk("cp_done_pulse", done, 0);
    rd(4'd8, v); chk("cp_status", v, 8'h02);
    rd(4'd0, v); chk("cp_src_lo", v, 8'h04);
    rd(4'd3, v); chk("cp_dst_lo", v, 8'h04);
    rd(4'd6, v); chk("cp_len_lo", v, 8'h00);

    // fill 3 bytes of 0xA5
    cfg_wr(4'd3, 8'h00); cfg_wr(4'd4, 8'h82); cfg_wr(4'd5, 8'h00);
    cfg_wr(4'd6, 8'd3);  cfg_wr(4'd9, 8'hA5);
    clr_log();
    cfg_wr(4'd8, 8'h03);
    rd(4'd8, v); chk("fl_status", v, 8'h01);
    wait_done(20);
    chk("fl_count", la.size(), 3);
    for (int i = 0; i < 3 && i < la.size(); i++) begin
      chk("fl_addr", la[i], 24'h008200 + i);
      chk("fl_data", ld[i], 8'hA5);
      chk("fl_we", lw[i], 1);
    end
    if (lc.size() == 3) chk("fl_consec", lc[2] - lc[0], 2);
    rd(4'd0, v); chk("fl_src_lo", v, 8'h04);
    rd(4'd1, v); chk("fl_src_mid", v, 8'h80);
    @(negedge clk);

    // halt during the first read
    set_xfer(24'h00C000, 24'h00D000, 16'd2);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    bus_halt = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hl_addr", address, 24'h00C000);
      chk("hl_be", bus_enable, 1);
      chk("hl_we", write_enable, 0);
    end
    chk("hl_nolog", la.size(), 0);
    bus_halt = 1'b0;
    wait_done(20);
    chk_pair(0, 24'h00C000, 24'h00D000, 8'hC1);
    chk_pair(1, 24'h00C001, 24'h00D001, 8'hC2);
    @(negedge clk);

    // grant handshake
    bus_grant = 1'b0;
    set_xfer(24'h001000, 24'h002000, 16'd3);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    for (int i = 0; i < 3; i++) begin
      chk("gr_req", bus_request, 1);
      chk("gr_be_low", bus_enable, 0);
      @(negedge clk);
    end
    bus_grant = 1'b1;
    wait_log(1, 20);
    bus_grant = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("gr_drop_be", bus_enable, 0);
    end
    chk("gr_drop_log", la.size(), 1);
    bus_grant = 1'b1;
    wait_done(30);
    for (int i = 0; i < 3; i++) chk_pair(i, 24'h001000 + i, 24'h002000 + i, 8'h11 + i);
    @(negedge clk);

    // len = 0: immediate done, no bus activity
    set_xfer(24'h001000, 24'h002000, 16'd0);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    chk("z_done", done, 1);
    chk("z_req", bus_request, 0);
    @(negedge clk);
    chk("z_done_pulse", done, 0);
    chk("z_log", la.size(), 0);
    rd(4'd8, v); chk("z_status", v, 8'h02);

    // source address wraps
    set_xfer(24'hFFFFFF, 24'h003000, 16'd2);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    wait_done(20);
    chk_pair(0, 24'hFFFFFF, 24'h003000, 8'hFF);
    chk_pair(1, 24'h000000, 24'h003001, 8'h01);
    rd(4'd2, v); chk("wr_src_hi", v, 8'h00);
    rd(4'd0, v); chk("wr_src_lo", v, 8'h01);
    @(negedge clk);

    // config write while busy is ignored
    set_xfer(24'h004000, 24'h005000, 16'd2);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    cfg_wr(4'd0, 8'h77);
    wait_done(20);
    chk_pair(0, 24'h004000, 24'h005000, 8'h41);
    chk_pair(1, 24'h004001, 24'h005001, 8'h42);
    rd(4'd0, v); chk("bz_src_lo", v, 8'h02);
    @(negedge clk);

    // abort during the 3rd byte, with the read halted
    set_xfer(24'h006000, 24'h007000, 16'd10);
    clr_log();
    cfg_wr(4'd8, 8'h01);
    wait_log(4, 40);
    bus_halt = 1'b1;
    cfg_wr(4'd8, 8'h81);
    chk("ab_done", done, 1);
    chk("ab_be", bus_enable, 0);
    chk("ab_req", bus_request, 0);
    chk("ab_busy", busy, 0);
    bus_halt = 1'b0;
    @(negedge clk);
    rd(4'd6, v); chk("ab_len_lo", v, 8'd8);
    rd(4'd7, v); chk("ab_len_hi", v, 8'd0);
    chk("ab_log", la.size(), 4);

    // async reset mid-transfer
    set_xfer(24'h001000, 24'h002000, 16'd5);
    cfg_wr(4'd8, 8'h01);
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("ar_be", bus_enable, 0);
    chk("ar_req", bus_request, 0);
    chk("ar_busy", busy, 0);
    chk("ar_addr", address, 0);
    rd(4'd8, v); chk("ar_status", v, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
